// File: rtl/divider_modulo_pipe.sv
// ============================================================================
// Module   : divider_modulo_pipe
// Brief    : Pipelined non-restoring unsigned divider/modulo, valid/ready I/O
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_modulo_pipe #(
    parameter int DIVIDEND_W     = 32,
    parameter int DIVISOR_W      = 16,
    parameter int ROWS_PER_STAGE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_mode,
    input  logic                  i_valid_in,
    output logic                  o_ready_in,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_valid_out,
    input  logic                  i_ready_out,
    output logic [DIVIDEND_W-1:0] o_result,
    output logic                  o_err
);
    localparam int Q_W = DIVIDEND_W - DIVISOR_W + 1;
    localparam int S   = (Q_W + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
    localparam int R_W = DIVISOR_W + 1;

    // Stage 0 captures the accepted operands; stage k feeds row group k.
    logic [R_W-1:0]        r_rem  [S];
    logic [Q_W-1:0]        r_quo  [S];
    logic [Q_W-1:0]        r_lo   [S];
    logic [DIVISOR_W-1:0]  r_dvs  [S];
    logic                  r_mode [S];
    logic                  r_err  [S];
    logic                  r_vld  [S];
    logic                  r_valid_out;
    logic [DIVIDEND_W-1:0] r_result;
    logic                  r_err_out;

    logic                  w_adv;
    logic                  w_err_in;
    logic [R_W-1:0]        w_sh;
    logic [R_W-1:0]        w_rem_nx [S];
    logic [Q_W-1:0]        w_quo_nx [S];
    logic [Q_W-1:0]        w_lo_nx  [S];
    logic [DIVISOR_W-1:0]  w_fin;
    logic [DIVIDEND_W-1:0] w_result;

    assign w_adv      = ~r_valid_out | i_ready_out;
    assign o_ready_in = w_adv;
    assign w_err_in   = (i_divisor == '0) |
                        ({1'b0, i_dividend[DIVIDEND_W-1:Q_W]} >= i_divisor);

    // Partial remainders stay within [-d, d), so R_W-bit modular arithmetic is exact.
    always_comb begin
        w_sh = '0;
        for (int k = 0; k < S; k++) begin
            w_rem_nx[k] = r_rem[k];
            w_quo_nx[k] = r_quo[k];
            w_lo_nx[k]  = r_lo[k];
            for (int j = 0; j < ROWS_PER_STAGE; j++) begin
                if (k * ROWS_PER_STAGE + j < Q_W) begin
                    w_sh = {w_rem_nx[k][R_W-2:0], w_lo_nx[k][Q_W-1]};
                    if (w_rem_nx[k][R_W-1])
                        w_sh = w_sh + {1'b0, r_dvs[k]};
                    else
                        w_sh = w_sh - {1'b0, r_dvs[k]};
                    w_rem_nx[k] = w_sh;
                    w_quo_nx[k] = {w_quo_nx[k][Q_W-2:0], ~w_sh[R_W-1]};
                    w_lo_nx[k]  = {w_lo_nx[k][Q_W-2:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        w_fin = w_rem_nx[S-1][DIVISOR_W-1:0] +
                (w_rem_nx[S-1][R_W-1] ? r_dvs[S-1] : '0);
        if (r_err[S-1])
            w_result = r_mode[S-1] ? '1 : '0;
        else if (r_mode[S-1])
            w_result = {{(DIVIDEND_W-Q_W){1'b0}}, w_quo_nx[S-1]};
        else
            w_result = {{(DIVIDEND_W-DIVISOR_W){1'b0}}, w_fin};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < S; k++) begin
                r_rem[k]  <= '0;
                r_quo[k]  <= '0;
                r_lo[k]   <= '0;
                r_dvs[k]  <= '0;
                r_mode[k] <= 1'b0;
                r_err[k]  <= 1'b0;
                r_vld[k]  <= 1'b0;
            end
            r_valid_out <= 1'b0;
            r_result    <= '0;
            r_err_out   <= 1'b0;
        end else if (w_adv) begin
            r_rem[0]  <= {2'b00, i_dividend[DIVIDEND_W-1:Q_W]};
            r_quo[0]  <= '0;
            r_lo[0]   <= i_dividend[Q_W-1:0];
            r_dvs[0]  <= i_divisor;
            r_mode[0] <= i_mode;
            r_err[0]  <= w_err_in;
            r_vld[0]  <= i_valid_in;
            for (int k = 1; k < S; k++) begin
                r_rem[k]  <= w_rem_nx[k-1];
                r_quo[k]  <= w_quo_nx[k-1];
                r_lo[k]   <= w_lo_nx[k-1];
                r_dvs[k]  <= r_dvs[k-1];
                r_mode[k] <= r_mode[k-1];
                r_err[k]  <= r_err[k-1];
                r_vld[k]  <= r_vld[k-1];
            end
            r_valid_out <= r_vld[S-1];
            r_result    <= w_result;
            r_err_out   <= r_err[S-1];
        end
    end

    assign o_valid_out = r_valid_out;
    assign o_result    = r_result;
    assign o_err       = r_err_out;

endmodule

`default_nettype wire

// File: tb/tb_divider_modulo_pipe.sv
// ============================================================================
// Module   : tb_divider_modulo_pipe
// Brief    : Self-checking bench for divider_modulo_pipe (default and 24/8/3)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_modulo_pipe;
    localparam int S_A = 5;
    localparam int S_B = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_mode, a_vin, a_rdy_in, a_vout, a_rout, a_err;
    logic [31:0] a_dd, a_res;
    logic [15:0] a_dv;
    logic        b_mode, b_vin, b_rdy_in, b_vout, b_rout, b_err;
    logic [23:0] b_dd, b_res;
    logic [7:0]  b_dv;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    divider_modulo_pipe u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_mode(a_mode), .i_valid_in(a_vin),
        .o_ready_in(a_rdy_in), .i_dividend(a_dd), .i_divisor(a_dv),
        .o_valid_out(a_vout), .i_ready_out(a_rout), .o_result(a_res), .o_err(a_err)
    );

    divider_modulo_pipe #(.DIVIDEND_W(24), .DIVISOR_W(8), .ROWS_PER_STAGE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_mode(b_mode), .i_valid_in(b_vin),
        .o_ready_in(b_rdy_in), .i_dividend(b_dd), .i_divisor(b_dv),
        .o_valid_out(b_vout), .i_ready_out(b_rout), .o_result(b_res), .o_err(b_err)
    );

    // Reference: plain integer division on the operation's own terms.
    function automatic logic [31:0] ref_div(input longint unsigned dd, input longint unsigned dv,
                                            input bit m, input int dw, input int vw, output bit e);
        int qw;
        qw = dw - vw + 1;
        e  = (dv == 0) || ((dd / dv) >= (64'd1 << qw));
        if (e) return m ? 32'((64'd1 << dw) - 1) : 32'd0;
        return m ? 32'(dd / dv) : 32'(dd % dv);
    endfunction

    task automatic do_op_a(input logic [31:0] dd, input logic [15:0] dv, input logic m,
                           output logic [31:0] res, output logic e, output int lat);
        a_dd = dd; a_dv = dv; a_mode = m; a_vin = 1'b1; a_rout = 1'b1;
        @(posedge clk); #1;
        a_vin = 1'b0;
        lat = 0;
        while (!a_vout && lat < 40) begin @(posedge clk); #1; lat++; end
        res = a_res; e = a_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (a_vout !== 1'b0 || a_res !== 32'd0 || a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b result=%h err=%b, required 0/0/0", a_vout, a_res, a_err);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (a_rdy_in !== 1'b1 || b_rdy_in !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: ready_in a=%b b=%b, required 1/1", a_rdy_in, b_rdy_in);
        end
    endtask

    task automatic test_basic();
        logic [31:0] r; logic e; int lat;
        do_op_a(32'd1000, 16'd7, 1'b1, r, e, lat);
        n_tests++;
        if (r !== 32'd142 || e !== 1'b0) begin
            n_fail++; $display("FAIL basic_quot: result=%0d err=%b, required 142/0", r, e);
        end
        n_tests++;
        if (lat !== S_A) begin
            n_fail++; $display("FAIL basic_latency: %0d cycles, required %0d", lat, S_A);
        end
        do_op_a(32'd1000, 16'd7, 1'b0, r, e, lat);
        n_tests++;
        if (r !== 32'd6 || e !== 1'b0) begin
            n_fail++; $display("FAIL basic_rem: result=%0d err=%b, required 6/0", r, e);
        end
    endtask

    task automatic test_max_quotient();
        logic [31:0] r; logic e; int lat;
        do_op_a(32'h0001_FFFF, 16'd2, 1'b1, r, e, lat);
        n_tests++;
        if (r !== 32'h0000_FFFF || e !== 1'b0) begin
            n_fail++; $display("FAIL maxq_quot: result=%h err=%b, required 0000ffff/0", r, e);
        end
        do_op_a(32'h0001_FFFF, 16'd2, 1'b0, r, e, lat);
        n_tests++;
        if (r !== 32'd1 || e !== 1'b0) begin
            n_fail++; $display("FAIL maxq_rem: result=%h err=%b, required 1/0", r, e);
        end
    endtask

    task automatic test_errors();
        logic [31:0] r; logic e; int lat;
        do_op_a(32'h0001_2345, 16'd0, 1'b1, r, e, lat);
        n_tests++;
        if (r !== 32'hFFFF_FFFF || e !== 1'b1) begin
            n_fail++; $display("FAIL err_div0: result=%h err=%b, required ffffffff/1", r, e);
        end
        do_op_a(32'hFFFF_0000, 16'd1, 1'b0, r, e, lat);
        n_tests++;
        if (r !== 32'd0 || e !== 1'b1) begin
            n_fail++; $display("FAIL err_overflow: result=%h err=%b, required 0/1", r, e);
        end
    endtask

    task automatic test_back_to_back(input int n, input int stall_c, input int stall_len);
        logic [31:0] q_res[$];
        bit          q_err[$];
        logic [31:0] dd, held, exp_r;
        logic [15:0] dv;
        logic        m;
        bit          exp_e, was_stalled;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; was_stalled = 0; held = '0;
        dd = $urandom >> $urandom_range(0, 16);
        dv = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        m  = 1'($urandom_range(0, 1));
        while (got < n && cyc < 300) begin
            a_rout = !(cyc >= stall_c && cyc < stall_c + stall_len);
            a_vin  = (sent < n);
            a_dd = dd; a_dv = dv; a_mode = m;
            #1;
            if (a_vout && !a_rout) begin
                n_tests++;
                if (a_rdy_in !== 1'b0 || (was_stalled && a_res !== held)) begin
                    n_fail++;
                    $display("FAIL stall_hold: ready_in=%b result=%h, required 0/%h", a_rdy_in, a_res, held);
                end
                held = a_res; was_stalled = 1;
            end else begin
                was_stalled = 0;
            end
            if (a_vout && a_rout) begin
                n_tests++;
                if (q_res.size() == 0) begin
                    n_fail++; $display("FAIL stream_spurious: result=%h with nothing outstanding", a_res);
                end else begin
                    exp_r = q_res.pop_front(); exp_e = q_err.pop_front();
                    if (a_res !== exp_r || a_err !== exp_e) begin
                        n_fail++;
                        $display("FAIL stream_result #%0d: result=%h err=%b, required %h/%b", got, a_res, a_err, exp_r, exp_e);
                    end
                end
                got++;
            end
            if (a_vin && a_rdy_in) begin
                q_res.push_back(ref_div(dd, dv, m, 32, 16, exp_e));
                q_err.push_back(exp_e);
                sent++;
                dd = $urandom >> $urandom_range(0, 16);
                dv = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
                m  = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1; cyc++;
        end
        a_vin = 1'b0; a_rout = 1'b1;
        n_tests++;
        if (got !== n || cyc !== n + S_A + 1 + stall_len) begin
            n_fail++;
            $display("FAIL stream_count: got %0d in %0d cycles, required %0d in %0d", got, cyc, n, n + S_A + 1 + stall_len);
        end
    endtask

    task automatic test_reset_inflight();
        int wait_c, spurious;
        a_rout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_dd = 32'd5000 + 32'(i); a_dv = 16'd3; a_mode = 1'b1; a_vin = 1'b1;
            @(posedge clk); #1;
        end
        a_vin = 1'b0;
        wait_c = 0;
        while (!a_vout && wait_c < 40) begin @(posedge clk); #1; wait_c++; end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (a_vout !== 1'b0 || a_res !== 32'd0 || wait_c >= 40) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b result=%h wait=%0d, required 0/0 within bound", a_vout, a_res, wait_c);
        end
        @(negedge clk); rst_n = 1'b1; a_rout = 1'b1;
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (a_vout) spurious++;
        end
        n_tests++;
        if (spurious !== 0 || a_rdy_in !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flush: %0d spurious outputs, ready_in=%b, required 0/1", spurious, a_rdy_in);
        end
    endtask

    task automatic test_small_params(input int n);
        logic [31:0] q_res[$];
        bit          q_err[$];
        logic [31:0] exp_r;
        logic [23:0] dd;
        logic [7:0]  dv;
        logic        m;
        bit          exp_e;
        int sent, got, cyc, lat;
        b_dd = 24'd1000; b_dv = 8'd7; b_mode = 1'b1; b_vin = 1'b1; b_rout = 1'b1;
        @(posedge clk); #1;
        b_vin = 1'b0; lat = 0;
        while (!b_vout && lat < 40) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if (lat !== S_B || b_res !== 24'd142 || b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL small_latency: %0d cycles result=%0d err=%b, required %0d/142/0", lat, b_res, b_err, S_B);
        end
        @(posedge clk); #1;
        sent = 0; got = 0; cyc = 0;
        dd = 24'($urandom) >> $urandom_range(0, 10);
        dv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        m  = 1'($urandom_range(0, 1));
        while (got < n && cyc < 400) begin
            b_rout = ($urandom_range(0, 3) != 0);
            b_vin  = (sent < n);
            b_dd = dd; b_dv = dv; b_mode = m;
            #1;
            if (b_vout && b_rout) begin
                n_tests++;
                if (q_res.size() == 0) begin
                    n_fail++; $display("FAIL small_spurious: result=%h with nothing outstanding", b_res);
                end else begin
                    exp_r = q_res.pop_front(); exp_e = q_err.pop_front();
                    if ({8'd0, b_res} !== exp_r || b_err !== exp_e) begin
                        n_fail++;
                        $display("FAIL small_result #%0d: result=%h err=%b, required %h/%b", got, b_res, b_err, exp_r, exp_e);
                    end
                end
                got++;
            end
            if (b_vin && b_rdy_in) begin
                q_res.push_back(ref_div(dd, dv, m, 24, 8, exp_e));
                q_err.push_back(exp_e);
                sent++;
                dd = 24'($urandom) >> $urandom_range(0, 10);
                dv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                m  = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1; cyc++;
        end
        b_vin = 1'b0; b_rout = 1'b1;
        n_tests++;
        if (got !== n) begin
            n_fail++; $display("FAIL small_count: got %0d results, required %0d", got, n);
        end
    endtask

    initial begin
        a_mode = 1'b0; a_vin = 1'b0; a_rout = 1'b1; a_dd = '0; a_dv = '0;
        b_mode = 1'b0; b_vin = 1'b0; b_rout = 1'b1; b_dd = '0; b_dv = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_max_quotient();
        test_errors();
        test_back_to_back(20, 100, 0);
        test_back_to_back(20, 10, 3);
        test_reset_inflight();
        test_small_params(20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
